// File: rtl/reorder_ctrl.sv
// Write/read control for the two-bank ping-pong reorder buffer behind a 128-point SDF FFT.
// Bit-reversed samples are scattered into one bank while the other bank is read in natural order.
module reorder_ctrl #(
  parameter int LOG_L_FFT = 7,
  parameter int N_REG     = 128,
  parameter int BIT_REV   = 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  input  logic                   sync_clr,
  output logic [2*N_REG-1:0]     en_reg_out_bus,
  output logic [LOG_L_FFT-1:0]   sel_out,
  output logic                   sel_bank_out,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   busy
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LOG_L_FFT-1:0] LAST = LOG_L_FFT'(N_REG - 1);

  state_t                 r_state, w_state_nxt;
  logic [LOG_L_FFT-1:0]   r_wr_cnt, r_rd_cnt, w_rd_cnt_nxt, w_wr_addr;
  logic                   r_wr_bank, r_rd_bank, w_rd_bank_nxt, w_frame_done;
  logic                   r_out_valid, r_out_sof, r_out_eof;

  function automatic logic [LOG_L_FFT-1:0] bitrev(input logic [LOG_L_FFT-1:0] a);
    logic [LOG_L_FFT-1:0] r;
    for (int i = 0; i < LOG_L_FFT; i++) r[i] = a[LOG_L_FFT-1-i];
    return r;
  endfunction

  // A restart with a sample present puts that sample at index 0 of the new frame.
  assign w_frame_done = in_valid && !sync_clr && (r_wr_cnt == LAST);
  assign w_wr_addr    = sync_clr ? '0 : ((BIT_REV != 0) ? bitrev(r_wr_cnt) : r_wr_cnt);

  // Bank0 occupies the upper half of the enable bus, hence the inverted bank bit.
  always_comb begin
    en_reg_out_bus = '0;
    if (in_valid && nrst) en_reg_out_bus[{~r_wr_bank, w_wr_addr}] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (in_valid) begin
      if (sync_clr) begin
        r_wr_cnt <= LOG_L_FFT'(1);
      end else begin
        r_wr_cnt <= r_wr_cnt + LOG_L_FFT'(1);
        if (r_wr_cnt == LAST) r_wr_bank <= ~r_wr_bank;
      end
    end else if (sync_clr) begin
      r_wr_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_rd_bank_nxt = r_rd_bank;
    case (r_state)
      IDLE: begin
        if (w_frame_done) begin
          w_state_nxt   = READ;
          w_rd_cnt_nxt  = '0;
          w_rd_bank_nxt = r_wr_bank;
        end
      end
      READ: begin
        w_rd_cnt_nxt = r_rd_cnt + LOG_L_FFT'(1);
        if (r_rd_cnt == LAST) begin
          if (w_frame_done) begin
            w_rd_cnt_nxt  = '0;
            w_rd_bank_nxt = r_wr_bank;
          end else begin
            w_state_nxt  = IDLE;
            w_rd_cnt_nxt = r_rd_cnt;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end

  // Flags lag the read select by one cycle to line up with the buffer's registered read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_out_valid <= (r_state == READ);
      r_out_sof   <= (r_state == READ) && (r_rd_cnt == '0);
      r_out_eof   <= (r_state == READ) && (r_rd_cnt == LAST);
    end
  end

  assign sel_out      = r_rd_cnt;
  assign sel_bank_out = r_rd_bank;
  assign busy         = (r_state == READ);
  assign out_valid    = r_out_valid;
  assign out_sof      = r_out_sof;
  assign out_eof      = r_out_eof;

endmodule

// File: tb/tb_reorder_ctrl.sv
// Scoreboard bench for reorder_ctrl: a write-side model predicts the enable bus and queues
// the read-select and output-flag timeline of every completed frame.
module tb_reorder_ctrl;

  localparam int L = 7;
  localparam int N = 128;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           in_valid = 1'b0;
  logic           sync_clr = 1'b0;
  logic [2*N-1:0] en_reg_out_bus;
  logic [L-1:0]   sel_out;
  logic           sel_bank_out, out_valid, out_sof, out_eof, busy;

  reorder_ctrl #(.LOG_L_FFT(L), .N_REG(N), .BIT_REV(1)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .sync_clr(sync_clr),
    .en_reg_out_bus(en_reg_out_bus), .sel_out(sel_out), .sel_bank_out(sel_bank_out),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int c; int k; bit bank;} ent_t;
  ent_t rd_q[$];
  ent_t ov_q[$];

  int errs = 0;
  int checks = 0;
  int m_cnt = 0;
  bit m_bank = 1'b0;

  task automatic check(input string tag, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [L-1:0] brev(input int a);
    logic [L-1:0] v, r;
    v = L'(a);
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  task automatic check_outputs();
    bit exp_busy, exp_ov;
    ent_t e;
    exp_busy = (rd_q.size() > 0) && (rd_q[0].c == cyc);
    check("busy", busy, exp_busy);
    if (exp_busy) begin
      e = rd_q.pop_front();
      check("sel_out", sel_out, e.k);
      check("sel_bank_out", sel_bank_out, e.bank);
    end
    exp_ov = (ov_q.size() > 0) && (ov_q[0].c == cyc);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      e = ov_q.pop_front();
      check("out_sof", out_sof, e.k == 0);
      check("out_eof", out_eof, e.k == N-1);
    end
  endtask

  task automatic step(input bit iv, input bit sc);
    logic [2*N-1:0] e;
    logic [L-1:0] a;
    @(posedge clk);
    #1;
    in_valid = iv;
    sync_clr = sc;
    @(negedge clk);
    e = '0;
    a = sc ? '0 : brev(m_cnt);
    if (iv) e[{~m_bank, a}] = 1'b1;
    check("en_bus", en_reg_out_bus, e);
    check_outputs();
    if (iv) begin
      if (sc) m_cnt = 1;
      else if (m_cnt == N-1) begin
        m_cnt = 0;
        for (int k = 0; k < N; k++) begin
          rd_q.push_back('{cyc + 1 + k, k, m_bank});
          ov_q.push_back('{cyc + 2 + k, k, m_bank});
        end
        m_bank = ~m_bank;
      end else m_cnt++;
    end else if (sc) m_cnt = 0;
  endtask

  task automatic do_reset(input bit hold_iv);
    #1;
    nrst = 1'b0;
    in_valid = hold_iv;
    sync_clr = 1'b0;
    #1;
    check("rst_en_bus", en_reg_out_bus, '0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sel_out", sel_out, 0);
    check("rst_sel_bank", sel_bank_out, 0);
    check("rst_sof_eof", {out_sof, out_eof}, 0);
    m_cnt = 0;
    m_bank = 1'b0;
    rd_q.delete();
    ov_q.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nrst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    do_reset(1'b1);

    // single continuous frame
    feed(N);
    idle(N + 8);

    // three back-to-back frames
    do_reset(1'b0);
    feed(3*N);
    idle(N + 8);

    // alternate-cycle input, two frames
    do_reset(1'b0);
    for (int i = 0; i < 4*N; i++) step(i % 2 == 0, 1'b0);
    idle(N + 8);

    // sync_clr with and without a coincident sample
    do_reset(1'b0);
    feed(50);
    step(1'b0, 1'b1);
    feed(N);
    idle(N + 8);
    feed(20);
    step(1'b1, 1'b1);
    feed(N - 1);
    idle(N + 8);

    // reset in the middle of a read phase
    do_reset(1'b0);
    feed(N);
    for (int i = 0; i < 3*N && !(rd_q.size() > 0 && rd_q[0].k == 61); i++) step(1'b0, 1'b0);
    check("reached_rd_60", rd_q.size() > 0 && rd_q[0].k == 61, 1);
    do_reset(1'b0);
    feed(100);
    idle(40);
    feed(N - 100);
    idle(N + 8);

    check("rd_q_drained", rd_q.size(), 0);
    check("ov_q_drained", ov_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
